// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_wr_arbiter
//  Purpose  : Round-robin burst arbiter sharing one FIFO write port between
//             num_ch valid/ready producers, with fifo_count back-pressure.
//  Revision : 1.0  initial release
// ============================================================================
module fifo_wr_arbiter #(
  parameter int data_width = 8,
  parameter int num_ch     = 4,
  parameter int fifo_depth = 64,
  parameter int burst_max  = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [num_ch-1:0]            ch_valid,
  input  logic [num_ch*data_width-1:0] ch_data,
  output logic [num_ch-1:0]            ch_ready,
  input  logic [7:0]                   fifo_count,
  output logic [data_width-1:0]        fifo_in,
  output logic                         w_enable,
  output logic [num_ch-1:0]            grant,
  output logic                         busy
);

  localparam int              c_pw        = (num_ch > 1) ? $clog2(num_ch) : 1;
  localparam int              c_bw        = $clog2(burst_max) + 1;
  localparam logic [c_bw-1:0] c_last_beat = c_bw'(burst_max - 1);
  localparam logic [c_pw-1:0] c_ptr_init  = c_pw'(num_ch - 1);
  localparam logic [8:0]      c_depth     = 9'(fifo_depth);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t                r_state;
  logic [num_ch-1:0]     r_grant;
  logic [c_pw-1:0]       r_gidx;
  logic [c_bw-1:0]       r_beat_cnt;
  logic [c_pw-1:0]       r_rr_ptr;
  logic [data_width-1:0] r_fifo_in;
  logic                  r_w_enable;

  state_t                w_state_nxt;
  logic [num_ch-1:0]     w_grant_nxt;
  logic [c_pw-1:0]       w_gidx_nxt;
  logic [c_bw-1:0]       w_beat_cnt_nxt;
  logic [c_pw-1:0]       w_rr_ptr_nxt;
  logic [data_width-1:0] w_fifo_in_nxt;
  logic                  w_w_enable_nxt;

  logic                  w_busy;
  logic                  w_space_ok;
  logic                  w_cur_valid;
  logic [data_width-1:0] w_cur_data;
  logic                  w_xfer;
  logic                  w_found;
  logic [c_pw-1:0]       w_sel;
  logic [c_pw-1:0]       w_idx;

  assign w_busy = (r_state == ST_GRANT);

  // The +w_enable term covers the word already presented but not yet counted.
  assign w_space_ok = ({1'b0, fifo_count} + {8'd0, r_w_enable}) < c_depth;

  // grant is one-hot, so masking selects the granted channel directly.
  always_comb begin
    w_cur_valid = |(ch_valid & r_grant);
    w_cur_data  = '0;
    for (int i = 0; i < num_ch; i++) begin
      if (r_grant[i]) begin
        w_cur_data = ch_data[i*data_width +: data_width];
      end
    end
  end

  assign w_xfer   = w_busy & w_space_ok & w_cur_valid;
  assign ch_ready = (w_busy && w_space_ok) ? r_grant : '0;

  // Walk downward so the nearest valid channel after rr_ptr wins.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_idx   = '0;
    for (int k = num_ch; k >= 1; k--) begin
      w_idx = c_pw'((int'(r_rr_ptr) + k) % num_ch);
      if (ch_valid[w_idx]) begin
        w_found = 1'b1;
        w_sel   = w_idx;
      end
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_grant_nxt    = r_grant;
    w_gidx_nxt     = r_gidx;
    w_beat_cnt_nxt = r_beat_cnt;
    w_rr_ptr_nxt   = r_rr_ptr;
    w_fifo_in_nxt  = r_fifo_in;
    w_w_enable_nxt = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_state_nxt    = ST_GRANT;
          w_gidx_nxt     = w_sel;
          w_beat_cnt_nxt = '0;
          for (int i = 0; i < num_ch; i++) begin
            w_grant_nxt[i] = (w_sel == c_pw'(i));
          end
        end
      end

      ST_GRANT: begin
        if (!w_cur_valid) begin
          w_state_nxt  = ST_IDLE;
          w_grant_nxt  = '0;
          w_rr_ptr_nxt = r_gidx;
        end else if (w_xfer) begin
          w_w_enable_nxt = 1'b1;
          w_fifo_in_nxt  = w_cur_data;
          if (r_beat_cnt == c_last_beat) begin
            w_state_nxt  = ST_IDLE;
            w_grant_nxt  = '0;
            w_rr_ptr_nxt = r_gidx;
          end else begin
            w_beat_cnt_nxt = r_beat_cnt + 1'b1;
          end
        end
        // A full-FIFO stall falls through: grant and beat count hold.
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_grant    <= '0;
      r_gidx     <= '0;
      r_beat_cnt <= '0;
      r_rr_ptr   <= c_ptr_init;
      r_fifo_in  <= '0;
      r_w_enable <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_grant    <= w_grant_nxt;
      r_gidx     <= w_gidx_nxt;
      r_beat_cnt <= w_beat_cnt_nxt;
      r_rr_ptr   <= w_rr_ptr_nxt;
      r_fifo_in  <= w_fifo_in_nxt;
      r_w_enable <= w_w_enable_nxt;
    end
  end

  assign fifo_in  = r_fifo_in;
  assign w_enable = r_w_enable;
  assign grant    = r_grant;
  assign busy     = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fifo_wr_arbiter
//  Purpose  : Scoreboard bench: transaction-level round-robin model predicts
//             grant order and write stream; a monitor compares DUT output.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fifo_wr_arbiter;

  localparam int NCH   = 4;
  localparam int BURST = 4;
  localparam int DEPTH = 64;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   ch_valid;
  logic [31:0]  ch_data;
  logic [3:0]   ch_ready;
  logic [7:0]   fifo_count;
  logic [7:0]   fifo_in;
  logic         w_enable;
  logic [3:0]   grant;
  logic         busy;

  int           total = 0;
  int           bad   = 0;
  logic [7:0]   pq [NCH][$];
  logic [7:0]   exp_data[$];
  int           exp_grant[$];
  int           model_ptr = NCH - 1;
  int           occ = 0;
  int           rd_pct = 0;
  bit           mon_en = 1'b1;
  int           hs_cnt[NCH];
  logic [3:0]   prev_grant = '0;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(
    .data_width(8), .num_ch(NCH), .fifo_depth(DEPTH), .burst_max(BURST)
  ) dut (
    .clk(clk), .rst(rst), .ch_valid(ch_valid), .ch_data(ch_data),
    .ch_ready(ch_ready), .fifo_count(fifo_count), .fifo_in(fifo_in),
    .w_enable(w_enable), .grant(grant), .busy(busy)
  );

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Whole-transaction model: producers never gain data mid-run, so each grant
  // takes min(burst, remaining) words from the next non-empty channel.
  task automatic plan();
    int off[NCH];
    int c;
    for (int i = 0; i < NCH; i++) off[i] = 0;
    forever begin
      c = -1;
      for (int k = 1; k <= NCH; k++) begin
        int idx = (model_ptr + k) % NCH;
        if (c < 0 && off[idx] < pq[idx].size()) c = idx;
      end
      if (c < 0) break;
      exp_grant.push_back(c);
      for (int b = 0; b < BURST && off[c] < pq[c].size(); b++) begin
        exp_data.push_back(pq[c][off[c]]);
        off[c]++;
      end
      model_ptr = c;
    end
  endtask

  // One clock: producers and FIFO occupancy emulated from the bench's side.
  task automatic step();
    logic [3:0] hs;
    logic       wen;
    bit         rd;
    @(negedge clk);
    for (int i = 0; i < NCH; i++) begin
      ch_valid[i]        = (pq[i].size() > 0);
      ch_data[i*8 +: 8]  = (pq[i].size() > 0) ? pq[i][0] : 8'h00;
    end
    fifo_count = 8'(occ);
    rd = (rd_pct > 0) && (occ > 0) && ($urandom_range(0, 99) < rd_pct);
    #1;
    hs  = ch_valid & ch_ready;
    wen = w_enable;
    @(posedge clk);
    #1;
    for (int i = 0; i < NCH; i++) begin
      if (hs[i]) begin
        void'(pq[i].pop_front());
        hs_cnt[i]++;
      end
    end
    occ = occ + int'(wen) - int'(rd);
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < NCH; i++) if (pq[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic run_until_done(input int budget);
    int n = 0;
    while (n < budget && !(all_empty() && !busy && !w_enable && exp_data.size() == 0)) begin
      step();
      n++;
    end
    check("drain_timeout", int'(n < budget), 1);
    check("grants_left", exp_grant.size(), 0);
  endtask

  task automatic clear_hs();
    for (int i = 0; i < NCH; i++) hs_cnt[i] = 0;
  endtask

  // Monitor: pops expectations whenever the DUT presents a write or a new grant.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (w_enable) begin
        check("write_while_full", int'(occ < DEPTH), 1);
        if (exp_data.size() == 0) check("unexpected_write", int'(fifo_in), -1);
        else check("write_data", int'(fifo_in), int'(exp_data.pop_front()));
      end
      if (grant != 4'b0 && prev_grant == 4'b0) begin
        if (exp_grant.size() == 0) check("unexpected_grant", int'(grant), 0);
        else check("grant_order", int'(grant), 1 << exp_grant.pop_front());
      end
    end
    prev_grant = grant;
  end

  initial begin
    int sum;
    rst = 1'b1; ch_valid = '0; ch_data = '0; fifo_count = '0;
    clear_hs();
    repeat (3) step();
    check("rst_grant", int'(grant), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_w_enable", int'(w_enable), 0);
    check("rst_fifo_in", int'(fifo_in), 0);
    rst = 1'b0;

    // All channels continuously valid: 4-beat bursts plus one bubble each.
    clear_hs(); occ = 0;
    for (int c = 0; c < NCH; c++)
      for (int b = 0; b < 8; b++) pq[c].push_back(8'((c << 4) | b));
    plan();
    repeat (20) step();
    sum = hs_cnt[0] + hs_cnt[1] + hs_cnt[2] + hs_cnt[3];
    check("beats_in_20_cycles", sum, 16);
    run_until_done(200);

    // Single beat on ch1; fifo_in must hold after the write.
    clear_hs(); occ = 0;
    pq[1].push_back(8'h96);
    plan();
    run_until_done(50);
    check("ch1_single_beat", hs_cnt[1], 1);
    check("fifo_in_hold", int'(fifo_in), 'h96);

    // Nearly full FIFO: one beat, then a held stall, then resume.
    clear_hs(); occ = 63;
    for (int b = 0; b < 4; b++) pq[0].push_back(8'(8'hA0 + b));
    plan();
    repeat (12) step();
    check("full_one_beat", hs_cnt[0], 1);
    check("full_busy_held", int'(busy), 1);
    check("full_grant_held", int'(grant), 1);
    check("full_occ", occ, 64);
    check("full_no_write", int'(w_enable), 0);
    occ = 60;
    run_until_done(100);
    check("resume_beats", hs_cnt[0], 4);
    check("resume_occ", occ, 63);

    // Early valid drop on ch2; ch3 is next ahead of ch0.
    clear_hs(); occ = 0;
    pq[2].push_back(8'h41); pq[2].push_back(8'h42);
    for (int b = 0; b < 3; b++) pq[3].push_back(8'(8'hC0 + b));
    for (int b = 0; b < 2; b++) pq[0].push_back(8'(8'hE0 + b));
    plan();
    run_until_done(100);
    check("ch2_two_beats", hs_cnt[2], 2);

    // ch3 fills an empty FIFO exactly.
    clear_hs(); occ = 0;
    for (int w = 'h50; w <= 'h8F; w++) pq[3].push_back(8'(w));
    plan();
    run_until_done(300);
    check("fill_beats", hs_cnt[3], 64);
    check("fill_occ", occ, 64);

    // Randomized rounds with random drain rate and starting occupancy.
    for (int r = 0; r < 6; r++) begin
      occ    = int'($urandom_range(30, 64));
      rd_pct = int'($urandom_range(20, 90));
      for (int c = 0; c < NCH; c++) begin
        int len = int'($urandom_range(0, 12));
        for (int b = 0; b < len; b++) pq[c].push_back(8'($urandom));
      end
      plan();
      run_until_done(2000);
    end
    rd_pct = 0;

    // Reset during the third beat of a burst.
    mon_en = 1'b0; clear_hs(); occ = 0;
    for (int b = 0; b < 4; b++) pq[0].push_back(8'(8'h70 + b));
    begin
      int n = 0;
      while (hs_cnt[0] < 2 && n < 30) begin step(); n++; end
      check("pre_reset_beats", hs_cnt[0], 2);
    end
    rst = 1'b1;
    step();
    check("midrst_grant", int'(grant), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_w_enable", int'(w_enable), 0);
    for (int i = 0; i < NCH; i++) pq[i].delete();
    rst = 1'b0; occ = 0; model_ptr = NCH - 1;
    step();
    mon_en = 1'b1;
    for (int c = 0; c < NCH; c++) begin
      if (c != 2) begin
        pq[c].push_back(8'(8'h30 + c));
        pq[c].push_back(8'(8'h38 + c));
      end
    end
    plan();
    run_until_done(100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
